// File: rtl/signed_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : signed_product_accumulator
//  Description : Accumulates groups of signed products into a saturating
//                signed sum. A group ends on in_last or after MAX_LEN
//                products. The result is held, with its product count and a
//                sticky saturation flag, until the consumer accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_product_accumulator #(
  parameter int PROD_W  = 18,
  parameter int ACC_W   = 20,
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PROD_W-1:0]          in_prod,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_sum,
  output logic [$clog2(MAX_LEN):0]   out_count,
  output logic                       out_sat
);

  localparam int CNT_W = $clog2(MAX_LEN) + 1;
  localparam int SUM_W = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     sat_q, sat_d;

  logic signed [SUM_W-1:0]  sum_w;
  logic                     pos_ovf_w;
  logic                     neg_ovf_w;
  logic signed [ACC_W-1:0]  clamped_w;
  logic [CNT_W-1:0]         count_inc_w;

  // Widened add of the running sum and the new product, then clamp to range
  always_comb begin
    sum_w       = SUM_W'(acc_q) + SUM_W'($signed(in_prod));
    // The extra top bit disagreeing with the accumulator sign bit means the
    // true result lies outside the ACC_W range.
    pos_ovf_w   = ~sum_w[SUM_W-1] &  sum_w[ACC_W-1];
    neg_ovf_w   =  sum_w[SUM_W-1] & ~sum_w[ACC_W-1];
    clamped_w   = sum_w[ACC_W-1:0];
    if (pos_ovf_w) begin
      clamped_w = ACC_MAX;
    end else if (neg_ovf_w) begin
      clamped_w = ACC_MIN;
    end
    count_inc_w = count_q + CNT_ONE;
  end

  // Next-state and next-register computation for the group FSM
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = ACC_W'($signed(in_prod));
          count_d = CNT_ONE;
          sat_d   = 1'b0;
          state_d = (in_last || (CNT_ONE == CNT_MAX)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d   = clamped_w;
          count_d = count_inc_w;
          sat_d   = sat_q | pos_ovf_w | neg_ovf_w;
          // in_last and a full group coincide into a single end of group
          state_d = (in_last || (count_inc_w == CNT_MAX)) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        count_d = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial group
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  // Handshake and result outputs decoded from registered state only
  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
    out_sum   = '0;
    out_count = '0;
    out_sat   = 1'b0;
    if (state_q == HOLD) begin
      out_sum   = acc_q;
      out_count = count_q;
      out_sat   = sat_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_signed_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signed_product_accumulator
//  Description : Self-checking bench for signed_product_accumulator. A
//                group-level arithmetic model predicts handshake and result
//                outputs every cycle; directed groups and a random run drive it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_product_accumulator;

  localparam int PROD_W  = 18;
  localparam int ACC_W   = 20;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;

  int tests = 0;
  int fails = 0;

  // Reference model: running group plus the finished group awaiting pickup
  bit     m_hold;
  longint m_acc;
  int     m_n;
  bit     m_sat;
  longint h_sum;
  int     h_cnt;
  bit     h_sat;

  signed_product_accumulator #(
    .PROD_W  (PROD_W),
    .ACC_W   (ACC_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [63:0] sum_bits(input longint v);
    return 64'(v) & ((64'd1 << ACC_W) - 64'd1);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_hold = 1'b0;
    m_acc  = 0;
    m_n    = 0;
    m_sat  = 1'b0;
    h_sum  = 0;
    h_cnt  = 0;
    h_sat  = 1'b0;
  endtask

  // Compare outputs to the model, apply this cycle's transfers, advance a clock
  task automatic cycle(output bit accepted);
    logic signed [PROD_W-1:0] p;
    longint v;
    check("in_ready",  in_ready,  !m_hold);
    check("out_valid", out_valid, m_hold);
    check("out_sum",   out_sum,   m_hold ? sum_bits(h_sum) : 64'd0);
    check("out_count", out_count, m_hold ? 64'(h_cnt) : 64'd0);
    check("out_sat",   out_sat,   m_hold & h_sat);
    accepted = in_valid && !m_hold;
    if (m_hold && out_ready) m_hold = 1'b0;
    if (accepted) begin
      p = in_prod;
      v = p;
      m_acc = m_acc + v;
      if (m_acc > ACC_MAX) begin
        m_acc = ACC_MAX;
        m_sat = 1'b1;
      end else if (m_acc < ACC_MIN) begin
        m_acc = ACC_MIN;
        m_sat = 1'b1;
      end
      m_n++;
      if (in_last || m_n == MAX_LEN) begin
        m_hold = 1'b1;
        h_sum  = m_acc;
        h_cnt  = m_n;
        h_sat  = m_sat;
        m_acc  = 0;
        m_n    = 0;
        m_sat  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) cycle(a);
  endtask

  task automatic send(input int val, input bit last);
    bit a;
    in_valid = 1'b1;
    in_prod  = PROD_W'(val);
    in_last  = last;
    a = 1'b0;
    for (int k = 0; k < 50 && !a; k++) cycle(a);
    if (!a) check("send_timeout", a, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sum"},   out_sum,   0);
    check({tag, "_out_count"}, out_count, 0);
    check({tag, "_out_sat"},   out_sat,   0);
  endtask

  initial begin
    bit a;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();

    // Reset state
    #2;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 100, -250, 1000 -> 850
    out_ready = 1'b1;
    send(100, 0);
    send(-250, 0);
    send(1000, 1);
    check("g1_valid", out_valid, 1);
    check("g1_sum",   out_sum,   850);
    check("g1_count", out_count, 3);
    check("g1_sat",   out_sat,   0);
    idle(1);

    // Single product held until the consumer takes it
    out_ready = 1'b0;
    send(65536, 1);
    check("g2_sum",   out_sum,   65536);
    check("g2_count", out_count, 1);
    check("g2_ready", in_ready,  0);
    idle(2);
    out_ready = 1'b1;
    idle(2);

    // Positive and negative saturation
    for (int i = 0; i < 9; i++) send(65536, 0);
    send(65536, 1);
    check("pos_sum",   out_sum,   524287);
    check("pos_sat",   out_sat,   1);
    check("pos_count", out_count, 10);
    idle(1);
    for (int i = 0; i < 9; i++) send(-65536, 0);
    send(-65536, 1);
    check("neg_sum",   out_sum,   sum_bits(-524288));
    check("neg_sat",   out_sat,   1);
    check("neg_count", out_count, 10);
    idle(1);

    // Group closed by length; 17th product waits through a stalled HOLD
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(1, 0);
    check("len_sum",   out_sum,   16);
    check("len_count", out_count, 16);
    in_valid = 1'b1;
    in_prod  = PROD_W'(1);
    in_last  = 1'b0;
    idle(5);
    check("stall_sum",   out_sum,   16);
    check("stall_ready", in_ready,  0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    idle(1);
    check_zero_outputs("drain");
    in_valid = 1'b1;
    cycle(a);
    check("17th_taken", a, 1);
    in_valid = 1'b0;
    send(5, 1);
    check("next_sum",   out_sum,   6);
    check("next_count", out_count, 2);
    idle(1);

    // Reset in the middle of a group
    out_ready = 1'b0;
    send(3, 0);
    send(4, 0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(7, 1);
    check("rst_sum",   out_sum,   7);
    check("rst_count", out_count, 1);
    out_ready = 1'b1;
    idle(1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) in_prod = PROD_W'($urandom);
      else in_prod = PROD_W'(int'($urandom_range(0, 400)) - 200);
      cycle(a);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
